mem_port_sequencer: RTL
=======================

MEM_PORT_SEQUENCER -- requirements
Module: mem_port_sequencer

Interface
REQ-001 Parameter: MEM_LAT, default 1, memory read latency in cycles; legal range 1..8.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ifReq  input  1  instruction-fetch request; held high until ifAck.
REQ-005 ifAddr  input  32  fetch address.
REQ-006 dReq  input  1  data (lw/sw) request; held high until dAck.
REQ-007 dWe  input  1  1 = store, 0 = load.
REQ-008 dAddr  input  32  data address.
REQ-009 dWData  input  32  store data.
REQ-010 memRData  input  32  read data from shared memory.
REQ-011 memAddr  output  32  address to shared memory.
REQ-012 memWData  output  32  write data to shared memory.
REQ-013 memWE  output  1  memory write strobe.
REQ-014 ifAck  output  1  one-cycle fetch completion pulse.
REQ-015 ifRData  output  32  fetched instruction.
REQ-016 dAck  output  1  one-cycle data completion pulse.
REQ-017 dRData  output  32  load data.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 txCount  output  16  completed-transaction counter.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, DONE; all outputs SHALL be registered or decoded from registered state only.
REQ-021 In IDLE, the block SHALL latch the winner's address, write enable (0 for fetch) and write data, record the owner, clear the latency counter and go to ACCESS.
REQ-022 Arbitration in IDLE SHALL be: only one requester high -> grant it; both high -> grant the port not granted last (lastData flag); no requester -> stay IDLE.
REQ-023 lastData SHALL update on every grant (1 = data, 0 = fetch).
REQ-024 In ACCESS, memAddr and memWData SHALL drive the latched values, and the counter SHALL increment each cycle.
REQ-025 memWE SHALL be 1 only in the first ACCESS cycle of a store and 0 at all other times.
REQ-026 On the edge ending the ACCESS cycle with counter == MEM_LAT-1, the block SHALL capture memRData into the owner's RData register (load or fetch only) and go to DONE.
REQ-027 In DONE, the owner's ack SHALL be 1 for exactly one cycle.
REQ-028 On the edge ending DONE, txCount SHALL increment by 1 (wrapping 0xFFFF -> 0x0000) and the state SHALL go to IDLE.
REQ-029 Latency: request sampled in IDLE at cycle T -> ACCESS cycles T+1..T+MEM_LAT -> ack in cycle T+MEM_LAT+1 -> IDLE at T+MEM_LAT+2.
REQ-030 No arbitration SHALL occur in ACCESS or DONE; requests arriving then SHALL wait for IDLE.
REQ-031 The acked requester SHALL deassert its req on the edge ending the ack cycle; a req still high in the following IDLE SHALL be treated as a new transaction.
REQ-032 If a requester drops req during ACCESS, the transaction SHALL still complete and ack normally.
REQ-033 A store SHALL leave dRData unchanged.
REQ-034 ifRData and dRData SHALL hold their values until the next completing read for the same port.
REQ-035 In IDLE, memAddr and memWData SHALL hold their last latched values.

Reset
REQ-036 reset SHALL force, on the same edge:
  - state = IDLE, counter = 0, lastData = 0;
  - memAddr, memWData, ifRData, dRData, txCount = 0;
  - memWE, ifAck, dAck, busy = 0.
REQ-037 Reset asserted in ACCESS or DONE SHALL abort the transaction with no ack and no txCount increment; reset overrides all other events.

Verification
REQ-038 MEM_LAT=1, fetch only: ifReq=1, ifAddr=0x40 in cycle 0, memRData=0x8C010004 -> memAddr=0x40 in cycle 1; ifAck=1 and ifRData=0x8C010004 in cycle 2; txCount=1.
REQ-039 MEM_LAT=1, simultaneous requests after reset: ifReq=dReq=1 in cycle 0 -> data granted first (dAck in cycle 2), then fetch (ifAck in cycle 5); busy=0 only in IDLE cycles.
REQ-040 MEM_LAT=3, store: dReq=1, dWe=1, dAddr=0x100, dWData=0xDEADBEEF -> memWE=1 only in cycle 1; dAck in cycle 4; dRData unchanged.
REQ-041 Both requesters held high continuously -> grants alternate data, fetch, data, fetch; no port receives two consecutive grants.
REQ-042 Reset in the second ACCESS cycle of a MEM_LAT=3 load -> next cycle: IDLE, dAck=0, memWE=0, txCount=0.
REQ-043 txCount preset to 0xFFFF via 65535 transactions, then one more -> txCount=0x0000.

Source files
------------

// File: rtl/mem_port_sequencer_if.sv
// Bus bundle between the fetch/data requesters, the shared memory and the sequencer.
// The slave modport is the sequencer's view; master is the client/memory side.
interface mem_port_sequencer_if;
   logic        ifReq;
   logic [31:0] ifAddr;
   logic        dReq;
   logic        dWe;
   logic [31:0] dAddr;
   logic [31:0] dWData;
   logic [31:0] memRData;
   logic [31:0] memAddr;
   logic [31:0] memWData;
   logic        memWE;
   logic        ifAck;
   logic [31:0] ifRData;
   logic        dAck;
   logic [31:0] dRData;
   logic        busy;
   logic [15:0] txCount;

   modport slave (
      input  ifReq, ifAddr, dReq, dWe, dAddr, dWData, memRData,
      output memAddr, memWData, memWE, ifAck, ifRData, dAck, dRData, busy, txCount
   );

   modport master (
      output ifReq, ifAddr, dReq, dWe, dAddr, dWData, memRData,
      input  memAddr, memWData, memWE, ifAck, ifRData, dAck, dRData, busy, txCount
   );
endinterface

// File: rtl/mem_port_sequencer.sv
// Arbitrates a fetch port and a data port onto one shared memory, one transaction
// at a time: IDLE (arbitrate) -> ACCESS (MEM_LAT cycles) -> DONE (ack pulse).
module mem_port_sequencer #(
   parameter int MEM_LAT = 1
) (
   input logic                  clock,
   input logic                  reset,
   mem_port_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q, state_d;
   logic [2:0]  cnt_q;
   logic        last_data_q;
   logic        owner_data_q;
   logic        we_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] if_rdata_q, d_rdata_q;
   logic [15:0] tx_cnt_q;
   logic        req_any, grant_data, last_beat;

   // On contention the port that did not win last time gets the grant.
   assign req_any    = bus.ifReq | bus.dReq;
   assign grant_data = bus.dReq & (~bus.ifReq | ~last_data_q);
   assign last_beat  = (cnt_q == 3'(MEM_LAT - 1));

   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_any) state_d = ACCESS;
         ACCESS:  if (last_beat) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q        <= '0;
         last_data_q  <= 1'b0;
         owner_data_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         if_rdata_q   <= '0;
         d_rdata_q    <= '0;
         tx_cnt_q     <= '0;
      end else begin
         case (state_q)
            IDLE: if (req_any) begin
               owner_data_q <= grant_data;
               last_data_q  <= grant_data;
               cnt_q        <= '0;
               addr_q       <= grant_data ? bus.dAddr : bus.ifAddr;
               we_q         <= grant_data & bus.dWe;
               wdata_q      <= grant_data ? bus.dWData : '0;
            end
            ACCESS: begin
               cnt_q <= cnt_q + 3'd1;
               // Stores never touch the read-data registers.
               if (last_beat && !we_q) begin
                  if (owner_data_q) d_rdata_q  <= bus.memRData;
                  else              if_rdata_q <= bus.memRData;
               end
            end
            DONE:    tx_cnt_q <= tx_cnt_q + 16'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.busy  = (state_q != IDLE);
      bus.memWE = (state_q == ACCESS) && we_q && (cnt_q == 3'd0);
      bus.ifAck = (state_q == DONE) && !owner_data_q;
      bus.dAck  = (state_q == DONE) && owner_data_q;
   end

   assign bus.memAddr  = addr_q;
   assign bus.memWData = wdata_q;
   assign bus.ifRData  = if_rdata_q;
   assign bus.dRData   = d_rdata_q;
   assign bus.txCount  = tx_cnt_q;
endmodule
